cmos_sccb_config: RTL and testbench

SCCB (I2C-compatible) register configuration sequencer for the CMOS sensor feeding the RGB565 capture path.
- After reset and a power-up delay, it walks an external register table and issues one 3-phase SCCB write per entry: device ID, 16-bit register address, 8-bit data.
- Asserts config_done when the table is exhausted, so downstream capture and frame-sync logic can qualify sensor output.
- Runs on the 24 MHz CMOS driver clock.

---
 rtl/cmos_sccb_config.sv | 222 ++++++++++++++++++++++
 tb/tb_cmos_sccb_config.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_sccb_config.sv
// SCCB register-table sequencer for the CMOS sensor: after a power-up delay it
// writes every {reg_addr, reg_data} table entry as a 3-phase SCCB write.
module cmos_sccb_config #(
  parameter int          CLK_FREQ      = 24_000_000,
  parameter int          SCCB_FREQ     = 100_000,
  parameter logic [7:0]  DEVICE_ID     = 8'h78,
  parameter logic [7:0]  LUT_SIZE      = 8'd252,
  parameter logic [23:0] POWERUP_DELAY = 24'd480_000
) (
  input  logic        clk_cmos,
  input  logic        rst_n,
  input  logic        cfg_start,
  output logic [7:0]  lut_index,
  input  logic [23:0] lut_data,
  output logic        sccb_scl,
  output logic        sccb_sda_out,
  output logic        sccb_sda_oe,
  input  logic        sccb_sda_in,
  output logic        config_busy,
  output logic        config_done,
  output logic        ack_err
);

  localparam int             DIV_RAW    = CLK_FREQ / (SCCB_FREQ * 4);
  localparam int             DIV        = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int             DIV_W      = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [7:0]     LAST_INDEX = LUT_SIZE - 8'd1;

  typedef enum logic [2:0] {
    PWRUP, IDLE, LOAD, START, BYTE, STOP, GAP, DONE
  } state_t;

  state_t             state;
  logic [23:0]        pwr_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic               counting;
  logic [1:0]         quarter;
  logic [3:0]         bit_cnt;
  logic [1:0]         byte_cnt;
  logic               load_cnt;
  logic [31:0]        shift;
  logic               sda_meta;
  logic               sda_sync;
  logic               scl_d;
  logic               sda_d;
  logic               oe_d;

  assign counting = (state == START) || (state == BYTE) ||
                    (state == STOP)  || (state == GAP);
  assign tick     = counting && (div_cnt == DIV_LAST);

  // Quarter-bit divider; held at zero outside the bus states so every
  // transaction begins with a full-length first quarter.
  always_ff @(posedge clk_cmos or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!counting || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_cmos or negedge rst_n) begin
    if (!rst_n) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= sccb_sda_in;
      sda_sync <= sda_meta;
    end
  end

  // Bus levels implied by the current state and quarter; registered below.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    oe_d  = 1'b0;
    case (state)
      START: begin
        oe_d  = 1'b1;
        sda_d = ~quarter[1];
      end
      BYTE: begin
        scl_d = (quarter == 2'd1) || (quarter == 2'd2);
        if (bit_cnt == 4'd8) begin
          oe_d  = 1'b0;
          sda_d = 1'b1;
        end else begin
          oe_d  = 1'b1;
          sda_d = shift[31];
        end
      end
      STOP: begin
        oe_d  = 1'b1;
        sda_d = quarter[1];
        scl_d = (quarter != 2'd0);
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        oe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_cmos or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PWRUP;
      pwr_cnt      <= '0;
      lut_index    <= '0;
      quarter      <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      load_cnt     <= 1'b0;
      shift        <= '0;
      config_busy  <= 1'b1;
      config_done  <= 1'b0;
      ack_err      <= 1'b0;
      sccb_scl     <= 1'b1;
      sccb_sda_out <= 1'b1;
      sccb_sda_oe  <= 1'b0;
    end else begin
      sccb_scl     <= scl_d;
      sccb_sda_out <= sda_d;
      sccb_sda_oe  <= oe_d;

      case (state)
        PWRUP: begin
          if ({1'b0, pwr_cnt} + 25'd1 >= {1'b0, POWERUP_DELAY}) begin
            state    <= LOAD;
            pwr_cnt  <= '0;
            load_cnt <= 1'b0;
          end else begin
            pwr_cnt <= pwr_cnt + 24'd1;
          end
        end

        IDLE: begin
          if (cfg_start) begin
            state       <= LOAD;
            lut_index   <= '0;
            config_done <= 1'b0;
            config_busy <= 1'b1;
            ack_err     <= 1'b0;
            load_cnt    <= 1'b0;
          end
        end

        // The table ROM is registered: lut_data is valid on the second cycle.
        LOAD: begin
          if (load_cnt) begin
            shift    <= {DEVICE_ID, lut_data};
            quarter  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            load_cnt <= 1'b0;
            state    <= START;
          end else begin
            load_cnt <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            quarter <= quarter + 2'd1;
            if (quarter == 2'd3) state <= BYTE;
          end
        end

        BYTE: begin
          if (tick) begin
            quarter <= quarter + 2'd1;
            // SCCB slaves may NACK freely; the error is only recorded.
            if (quarter == 2'd2 && bit_cnt == 4'd8 && sda_sync) ack_err <= 1'b1;
            if (quarter == 2'd3) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt  <= '0;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                shift   <= {shift[30:0], 1'b0};
              end
            end
          end
        end

        STOP: begin
          if (tick) begin
            quarter <= quarter + 2'd1;
            if (quarter == 2'd3) state <= GAP;
          end
        end

        GAP: begin
          if (tick) begin
            quarter <= quarter + 2'd1;
            if (quarter == 2'd3) begin
              if (lut_index == LAST_INDEX) begin
                state       <= DONE;
                config_done <= 1'b1;
                config_busy <= 1'b0;
              end else begin
                lut_index <= lut_index + 8'd1;
                load_cnt  <= 1'b0;
                state     <= LOAD;
              end
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_sccb_config.sv
// Randomized bench for cmos_sccb_config: a bus monitor decodes SCCB writes and
// a queue-based reference of the table contents predicts every transaction.
module tb_cmos_sccb_config;

  localparam int CLK_FREQ  = 400;
  localparam int SCCB_FREQ = 25;
  localparam int DIV       = 4;
  localparam int PWR       = 10;
  localparam int NLUT      = 3;
  localparam int TXN_CYC   = 156 * DIV + 2;
  localparam int RUN_LIMIT = NLUT * TXN_CYC + 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  lut_index;
  logic [23:0] lut_data;
  logic        scl, sda_out, sda_oe, sda_in;
  logic        busy, done, ack_err;

  logic [23:0] rom [0:255];
  logic        slave_low = 1'b0;
  logic [11:0] nack_mask = '0;
  int          run_base = 0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  logic [31:0] cap_word [$];
  int          cap_start [$];
  int          cap_stop [$];
  logic [7:0]  cap_idx [$];
  int          done_t = 0;
  logic        done_busy = 1'b0;

  logic        mon_in = 1'b0;
  int          mon_bits = 0;
  int          mon_bytes = 0;
  logic [31:0] mon_word = '0;
  logic [7:0]  mon_byte = '0;
  int          mon_start = 0;
  logic [7:0]  mon_idx = '0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        prev_done = 1'b0;
  logic        ack_phase = 1'b0;

  cmos_sccb_config #(
    .CLK_FREQ(CLK_FREQ), .SCCB_FREQ(SCCB_FREQ), .DEVICE_ID(8'h78),
    .LUT_SIZE(8'(NLUT)), .POWERUP_DELAY(24'(PWR))
  ) dut (
    .clk_cmos(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .lut_index(lut_index), .lut_data(lut_data),
    .sccb_scl(scl), .sccb_sda_out(sda_out), .sccb_sda_oe(sda_oe),
    .sccb_sda_in(sda_in), .config_busy(busy), .config_done(done),
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) lut_data <= rom[lut_index];

  // Open-drain line: master drives when enabled, otherwise slave or pull-up.
  assign sda_in = sda_oe ? sda_out : ~slave_low;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic nack_for(input int e, input int b);
    int k;
    if (e < 0 || e >= NLUT || b < 0 || b > 3) return 1'b0;
    k = e * 4 + b;
    return nack_mask[k];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_in = 1'b0; mon_bits = 0; mon_bytes = 0;
      slave_low = 1'b0; ack_phase = 1'b0;
      prev_scl = 1'b1; prev_sda = 1'b1; prev_done = 1'b0;
    end else begin
      if (done && !prev_done) begin
        done_t = cyc;
        done_busy = busy;
      end
      if (prev_scl && scl && prev_sda && !sda_in) begin
        mon_in = 1'b1; mon_bits = 0; mon_bytes = 0; mon_word = '0;
        mon_start = cyc; mon_idx = lut_index;
      end else if (prev_scl && scl && !prev_sda && sda_in) begin
        if (mon_in && mon_bytes == 4) begin
          cap_word.push_back(mon_word);
          cap_start.push_back(mon_start);
          cap_stop.push_back(cyc);
          cap_idx.push_back(mon_idx);
        end
        mon_in = 1'b0;
      end else if (mon_in && !prev_scl && scl) begin
        mon_bits++;
        if (mon_bits <= 8) begin
          mon_byte = {mon_byte[6:0], sda_in};
          if (mon_bits == 8 && mon_bytes < 4) begin
            mon_word = {mon_word[23:0], mon_byte};
            slave_low = !nack_for(cap_word.size() - run_base, mon_bytes);
          end
        end else begin
          check_eq("ack_released", 32'(sda_oe), 32'd0);
          mon_bytes++;
          mon_bits = 0;
          ack_phase = 1'b1;
        end
      end else if (prev_scl && !scl && ack_phase) begin
        slave_low = 1'b0;
        ack_phase = 1'b0;
      end
      prev_scl = scl;
      prev_sda = sda_in;
      prev_done = done;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic randomize_table();
    for (int i = 0; i < NLUT; i++) rom[i] = 24'($urandom);
    nack_mask = 12'($urandom) & 12'($urandom) & 12'($urandom);
  endtask

  task automatic wait_and_check_run();
    int found;
    int lat;
    int n;
    found = 0;
    for (int i = 0; i < RUN_LIMIT; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
    @(negedge clk);
    check_eq("done_reached", 32'(found), 32'd1);
    check_eq("busy_after_done", 32'(busy), 32'd0);
    check_eq("index_hold", 32'(lut_index), 32'(NLUT - 1));
    check_eq("ack_err", 32'(ack_err), 32'(nack_mask != 0));
    check_eq("done_with_busy_low", 32'(done_busy), 32'd0);
    n = cap_word.size() - run_base;
    check_eq("txn_count", 32'(n), 32'(NLUT));
    for (int e = 0; e < NLUT; e++) begin
      if (run_base + e < cap_word.size()) begin
        check_eq("txn_bytes", cap_word[run_base + e], {8'h78, rom[e]});
        check_eq("txn_index", 32'(cap_idx[run_base + e]), 32'(e));
        if (e > 0)
          check_eq("txn_spacing", 32'(cap_start[run_base + e] - cap_start[run_base + e - 1]),
                   32'(TXN_CYC));
      end
    end
    if (n > 0) begin
      lat = done_t - cap_stop[cap_stop.size() - 1];
      check_eq("done_after_gap", 32'(lat >= 6 * DIV - 2 && lat <= 6 * DIV + 1), 32'd1);
    end
  endtask

  initial begin
    int rel;
    int idle_bad;
    int lat;
    int found;

    for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);
    rom[0] = 24'h300882;
    nack_mask = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_scl", 32'(scl), 32'd1);
    check_eq("rst_sda", 32'(sda_out), 32'd1);
    check_eq("rst_oe", 32'(sda_oe), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ack_err", 32'(ack_err), 32'd0);
    check_eq("rst_index", 32'(lut_index), 32'd0);

    // Power-up run, with a cfg_start pulse mid-transaction that must be ignored.
    run_base = cap_word.size();
    rst_n = 1'b1;
    rel = cyc;
    idle_bad = 0;
    repeat (PWR) begin
      @(negedge clk);
      if (!(scl && sda_in && !sda_oe && busy)) idle_bad++;
    end
    check_eq("pwrup_idle", 32'(idle_bad), 32'd0);
    repeat (300) @(negedge clk);
    check_eq("busy_mid_txn", 32'(busy), 32'd1);
    pulse_start();
    wait_and_check_run();
    if (cap_start.size() > 0) begin
      lat = cap_start[0] - rel;
      check_eq("first_start_time",
               32'(lat >= PWR + 2 * DIV + 1 && lat <= PWR + 2 * DIV + 4), 32'd1);
    end
    check_eq("idle_scl", 32'(scl), 32'd1);
    check_eq("idle_oe", 32'(sda_oe), 32'd0);

    // NACK on the second byte of entry 1.
    nack_mask = '0;
    nack_mask[5] = 1'b1;
    run_base = cap_word.size();
    pulse_start();
    check_eq("start_clears_done", 32'(done), 32'd0);
    check_eq("start_sets_busy", 32'(busy), 32'd1);
    wait_and_check_run();

    // Replays with random tables and random NACK patterns.
    for (int r = 0; r < 3; r++) begin
      randomize_table();
      run_base = cap_word.size();
      pulse_start();
      check_eq("start_clears_ack_err", 32'(ack_err), 32'd0);
      check_eq("start_index_zero", 32'(lut_index), 32'd0);
      wait_and_check_run();
    end

    // Reset in the middle of entry 1, then a full restart from index 0.
    randomize_table();
    nack_mask = '0;
    run_base = cap_word.size();
    pulse_start();
    found = 0;
    for (int i = 0; i < RUN_LIMIT; i++) begin
      @(negedge clk);
      if (cap_word.size() - run_base == 1 && mon_in && mon_bytes >= 1) begin
        found = 1;
        break;
      end
    end
    check_eq("reach_entry1_byte", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_scl", 32'(scl), 32'd1);
    check_eq("midrst_sda", 32'(sda_out), 32'd1);
    check_eq("midrst_oe", 32'(sda_oe), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd1);
    check_eq("midrst_index", 32'(lut_index), 32'd0);
    repeat (5) @(negedge clk);
    run_base = cap_word.size();
    rst_n = 1'b1;
    wait_and_check_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
